// File: rtl/debug_pkg.sv
// ============================================================================
// debug_pkg: command codes, ACK byte, FSM encoding and sizing helper. Rev 1.0
// ============================================================================
`default_nettype none

package debug_pkg;

  localparam logic [7:0] CMD_PROGRAM = 8'h01;
  localparam logic [7:0] CMD_RUN     = 8'h02;
  localparam logic [7:0] CMD_STEP    = 8'h03;
  localparam logic [7:0] CMD_DUMP    = 8'h04;
  localparam logic [7:0] ACK_BYTE    = 8'hA5;

  // Encoding is visible on state_out; IDLE must stay at zero.
  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_PRG_LEN      = 4'd1,
    ST_PRG_DATA     = 4'd2,
    ST_PRG_ACK      = 4'd3,
    ST_PRG_ACK_WAIT = 4'd4,
    ST_RUN          = 4'd5,
    ST_STEP         = 4'd6,
    ST_DUMP_LOAD    = 4'd7,
    ST_DUMP_SEND    = 4'd8,
    ST_DUMP_WAIT    = 4'd9
  } state_e;

  function automatic int bytes_per_word(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debug_controller_byte_serializer.sv
// ============================================================================
// byte_serializer: shadow-latches a wide word and presents it LSB byte first. Rev 1.0
// ============================================================================
`default_nettype none

module byte_serializer #(
  parameter int WIDTH  = 128,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              shift_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              last_o
);

  localparam int NUM_BYTES = WIDTH / BYTE_W;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      shadow_d = data_i;
      cnt_d    = '0;
    end else if (shift_i) begin
      shadow_d = shadow_q >> BYTE_W;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign byte_o = shadow_q[BYTE_W-1:0];
  assign last_o = (cnt_q == CNT_W'(NUM_BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/debug_controller.sv
// ============================================================================
// debug_controller: UART command decoder for MIPS program load, run/step and dump. Rev 1.0
// ============================================================================
`default_nettype none

module debug_controller
  import debug_pkg::*;
#(
  parameter int NBIT_DATA_LEN = 8,
  parameter int len_data      = 32,
  parameter int INST_ADDR_W   = 8,
  parameter int NUM_DBG_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0]          rx_data_in,
  input  logic                              tx_done_tick,
  output logic                              tx_start,
  output logic [NBIT_DATA_LEN-1:0]          data_out,
  input  logic                              halt,
  input  logic [NUM_DBG_WORDS*len_data-1:0] dbg_bus,
  output logic [INST_ADDR_W-1:0]            addr_mem_inst,
  output logic [len_data-1:0]               ins_to_mem,
  output logic                              wr_ram_inst,
  output logic                              ctrl_clk_mips,
  output logic                              reset_mips,
  output logic [3:0]                        state_out
);

  localparam int BYTES_PER_WORD = bytes_per_word(len_data, NBIT_DATA_LEN);
  localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  state_e                   state_q, state_d;
  logic [NBIT_DATA_LEN-1:0] words_left_q, words_left_d;
  logic [BCNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [len_data-1:0]      word_q, word_d;
  logic [INST_ADDR_W-1:0]   addr_q, addr_d;
  logic                     wr_q, wr_d;
  logic                     tx_start_q, tx_start_d;
  logic [NBIT_DATA_LEN-1:0] data_out_q, data_out_d;
  logic                     ctrl_q, ctrl_d;
  logic                     rstm_q, rstm_d;

  logic                     ser_load;
  logic                     ser_shift;
  logic                     ser_last;
  logic [NBIT_DATA_LEN-1:0] ser_byte;

  function automatic logic is_code(input logic [NBIT_DATA_LEN-1:0] b, input logic [7:0] code);
    return b == NBIT_DATA_LEN'(code);
  endfunction

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wr_d         = 1'b0;
    tx_start_d   = 1'b0;
    data_out_d   = data_out_q;
    ctrl_d       = ctrl_q;
    rstm_d       = 1'b0;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;

    // Address advances on the cycle the write strobe is visible.
    if (wr_q) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_done_tick) begin
          if (is_code(rx_data_in, CMD_PROGRAM)) begin
            state_d = ST_PRG_LEN;
            rstm_d  = 1'b1;
            addr_d  = '0;
          end else if (is_code(rx_data_in, CMD_RUN)) begin
            state_d = halt ? ST_DUMP_LOAD : ST_RUN;
            ctrl_d  = ~halt;
          end else if (is_code(rx_data_in, CMD_STEP)) begin
            state_d = halt ? ST_DUMP_LOAD : ST_STEP;
            ctrl_d  = ~halt;
          end else if (is_code(rx_data_in, CMD_DUMP)) begin
            state_d = ST_DUMP_LOAD;
          end
        end
      end

      ST_PRG_LEN: begin
        if (rx_done_tick) begin
          words_left_d = rx_data_in;
          byte_cnt_d   = '0;
          state_d      = (rx_data_in == '0) ? ST_PRG_ACK : ST_PRG_DATA;
        end
      end

      ST_PRG_DATA: begin
        if (rx_done_tick) begin
          // Shift in at the top so the first byte ends up least significant.
          word_d = (word_q >> NBIT_DATA_LEN)
                 | (len_data'(rx_data_in) << (len_data - NBIT_DATA_LEN));
          if (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
            byte_cnt_d   = '0;
            wr_d         = 1'b1;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q == NBIT_DATA_LEN'(1)) begin
              state_d = ST_PRG_ACK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      ST_PRG_ACK: begin
        tx_start_d = 1'b1;
        data_out_d = NBIT_DATA_LEN'(ACK_BYTE);
        state_d    = ST_PRG_ACK_WAIT;
      end

      ST_PRG_ACK_WAIT: begin
        if (tx_done_tick) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (halt) begin
          ctrl_d  = 1'b0;
          state_d = ST_DUMP_LOAD;
        end
      end

      ST_STEP: begin
        ctrl_d  = 1'b0;
        state_d = ST_DUMP_LOAD;
      end

      ST_DUMP_LOAD: begin
        ser_load = 1'b1;
        state_d  = ST_DUMP_SEND;
      end

      ST_DUMP_SEND: begin
        tx_start_d = 1'b1;
        data_out_d = ser_byte;
        state_d    = ST_DUMP_WAIT;
      end

      ST_DUMP_WAIT: begin
        if (tx_done_tick) begin
          if (ser_last) begin
            state_d = ST_IDLE;
          end else begin
            ser_shift = 1'b1;
            state_d   = ST_DUMP_SEND;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      tx_start_q   <= 1'b0;
      data_out_q   <= '0;
      ctrl_q       <= 1'b0;
      rstm_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      tx_start_q   <= tx_start_d;
      data_out_q   <= data_out_d;
      ctrl_q       <= ctrl_d;
      rstm_q       <= rstm_d;
    end
  end

  byte_serializer #(
    .WIDTH  (NUM_DBG_WORDS * len_data),
    .BYTE_W (NBIT_DATA_LEN)
  ) u_dump_ser (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ser_load),
    .data_i  (dbg_bus),
    .shift_i (ser_shift),
    .byte_o  (ser_byte),
    .last_o  (ser_last)
  );

  assign tx_start      = tx_start_q;
  assign data_out      = data_out_q;
  assign addr_mem_inst = addr_q;
  assign ins_to_mem    = word_q;
  assign wr_ram_inst   = wr_q;
  assign ctrl_clk_mips = ctrl_q;
  assign reset_mips    = rstm_q;
  assign state_out     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_controller.sv
// ============================================================================
// tb_debug_controller: randomized bench with a UART model and spec-level reference. Rev 1.0
// ============================================================================
`default_nettype none

module tb_debug_controller;

  localparam int NB     = 8;
  localparam int LD     = 32;
  localparam int AW     = 8;
  localparam int NW     = 4;
  localparam int NBYTES = NW * LD / NB;
  localparam int BUDGET = 3000;

  logic            clk          = 1'b0;
  logic            reset        = 1'b0;
  logic            rx_done_tick = 1'b0;
  logic [NB-1:0]   rx_data_in   = '0;
  logic            tx_done_tick = 1'b0;
  logic            halt         = 1'b0;
  logic [NW*LD-1:0] dbg_bus     = '0;
  logic            tx_start;
  logic [NB-1:0]   data_out;
  logic [AW-1:0]   addr_mem_inst;
  logic [LD-1:0]   ins_to_mem;
  logic            wr_ram_inst;
  logic            ctrl_clk_mips;
  logic            reset_mips;
  logic [3:0]      state_out;

  always #5 clk = ~clk;

  debug_controller #(
    .NBIT_DATA_LEN (NB),
    .len_data      (LD),
    .INST_ADDR_W   (AW),
    .NUM_DBG_WORDS (NW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_done_tick  (rx_done_tick),
    .rx_data_in    (rx_data_in),
    .tx_done_tick  (tx_done_tick),
    .tx_start      (tx_start),
    .data_out      (data_out),
    .halt          (halt),
    .dbg_bus       (dbg_bus),
    .addr_mem_inst (addr_mem_inst),
    .ins_to_mem    (ins_to_mem),
    .wr_ram_inst   (wr_ram_inst),
    .ctrl_clk_mips (ctrl_clk_mips),
    .reset_mips    (reset_mips),
    .state_out     (state_out)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [NB-1:0] tx_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [LD-1:0] wr_data_q[$];
  int            ctrl_cnt = 0;
  int            rstm_cnt = 0;
  int            gap_viol = 0;
  logic          tx_busy  = 1'b0;
  int            tx_delay = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: captures each byte, answers with a delayed done strobe.
  always @(negedge clk) begin
    tx_done_tick = 1'b0;
    if (tx_start) begin
      if (tx_busy) gap_viol++;
      tx_q.push_back(data_out);
      tx_busy  = 1'b1;
      tx_delay = $urandom_range(1, 5);
    end else if (tx_busy) begin
      if (tx_delay == 0) begin
        tx_done_tick = 1'b1;
        tx_busy      = 1'b0;
      end else begin
        tx_delay = tx_delay - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (wr_ram_inst) begin
      wr_addr_q.push_back(addr_mem_inst);
      wr_data_q.push_back(ins_to_mem);
    end
    if (ctrl_clk_mips) ctrl_cnt++;
    if (reset_mips)    rstm_cnt++;
  end

  function automatic logic [NW*LD-1:0] rand_dbg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data_in   = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data_in   = NB'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input bit scramble);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      if (scramble) dbg_bus = rand_dbg();
      cyc++;
    end while ((state_out != 4'd0 || tx_busy) && cyc < BUDGET);
    check({tag, "_done_in_budget"}, 64'(cyc < BUDGET), 64'd1);
  endtask

  task automatic check_dump(input string tag, input logic [NW*LD-1:0] exp, input int tx0);
    logic [7:0] e;
    check({tag, "_nbytes"}, 64'(tx_q.size() - tx0), 64'(NBYTES));
    for (int i = 0; i < NBYTES; i++) begin
      e = 8'(exp >> (8 * i));
      if (tx0 + i < tx_q.size())
        check($sformatf("%s_byte%0d", tag, i), 64'(tx_q[tx0 + i]), 64'(e));
    end
  endtask

  task automatic do_program(input string tag, input logic [LD-1:0] w[$]);
    int wr0, tx0, r0;
    wr0 = wr_addr_q.size();
    tx0 = tx_q.size();
    r0  = rstm_cnt;
    send_byte(8'h01, $urandom_range(0, 2));
    send_byte(8'(w.size()), $urandom_range(0, 2));
    foreach (w[i])
      for (int b = 0; b < LD / NB; b++)
        send_byte(8'(w[i] >> (8 * b)), $urandom_range(0, 2));
    wait_idle(tag, 1'b0);
    check({tag, "_reset_mips_cycles"}, 64'(rstm_cnt - r0), 64'd1);
    check({tag, "_nwrites"}, 64'(wr_addr_q.size() - wr0), 64'(w.size()));
    foreach (w[i]) begin
      if (wr0 + i < wr_addr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[wr0 + i]), 64'(i % (1 << AW)));
        check($sformatf("%s_data%0d", tag, i), 64'(wr_data_q[wr0 + i]), 64'(w[i]));
      end
    end
    check({tag, "_ack_count"}, 64'(tx_q.size() - tx0), 64'd1);
    if (tx0 < tx_q.size()) check({tag, "_ack_byte"}, 64'(tx_q[tx0]), 64'hA5);
  endtask

  task automatic do_step(input string tag, input bit pre_halt, input logic [NW*LD-1:0] d);
    int c0, tx0;
    c0      = ctrl_cnt;
    tx0     = tx_q.size();
    dbg_bus = d;
    halt    = pre_halt;
    send_byte(8'h03, 0);
    wait_idle(tag, 1'b0);
    check({tag, "_ctrl_cycles"}, 64'(ctrl_cnt - c0), pre_halt ? 64'd0 : 64'd1);
    check_dump(tag, d, tx0);
    halt = 1'b0;
  endtask

  task automatic do_run(input string tag, input int h, input bit pre_halt);
    logic [NW*LD-1:0] d;
    int c0, tx0;
    d       = rand_dbg();
    c0      = ctrl_cnt;
    tx0     = tx_q.size();
    dbg_bus = d;
    halt    = pre_halt;
    send_byte(8'h02, 0);
    if (!pre_halt) begin
      repeat (h - 1) @(negedge clk);
      halt = 1'b1;
    end
    wait_idle(tag, 1'b0);
    check({tag, "_ctrl_cycles"}, 64'(ctrl_cnt - c0), pre_halt ? 64'd0 : 64'(h));
    check_dump(tag, d, tx0);
    halt = 1'b0;
  endtask

  task automatic do_dump(input string tag);
    logic [NW*LD-1:0] d;
    int tx0;
    d       = rand_dbg();
    tx0     = tx_q.size();
    dbg_bus = d;
    send_byte(8'h04, 0);
    wait_idle(tag, 1'b1);
    check_dump(tag, d, tx0);
  endtask

  initial begin
    logic [LD-1:0] words[$];
    int wr0, tx0, op;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({tx_start, data_out, addr_mem_inst, ins_to_mem, wr_ram_inst, ctrl_clk_mips, reset_mips}),
          64'd0);
    check("reset_state", 64'(state_out), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    words = '{32'h1234_5678, 32'hDEAD_BEEF};
    do_program("prg_directed", words);
    words = '{};
    do_program("prg_empty", words);

    do_step("step_directed", 1'b0, {32'h4, 32'h3, 32'h2, 32'h1});
    do_step("step_halted", 1'b1, rand_dbg());

    do_run("run_directed", 50, 1'b0);
    do_run("run_halted", 1, 1'b1);

    do_dump("dump_scrambled");

    tx0 = tx_q.size();
    send_byte(8'h7F, 0);
    check("unknown_cmd_state", 64'(state_out), 64'd0);
    repeat (3) @(negedge clk);
    check("unknown_cmd_no_tx", 64'(tx_q.size() - tx0), 64'd0);
    do_dump("dump_after_unknown");

    wr0 = wr_addr_q.size();
    send_byte(8'h01, 1);
    send_byte(8'h03, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_outputs",
          64'({tx_start, data_out, addr_mem_inst, ins_to_mem, wr_ram_inst, ctrl_clk_mips, reset_mips}),
          64'd0);
    check("async_rst_state", 64'(state_out), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("async_rst_no_write", 64'(wr_addr_q.size() - wr0), 64'd0);
    words = '{$urandom};
    do_program("prg_after_reset", words);

    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          words = '{};
          for (int k = 0; k < $urandom_range(0, 4); k++) words.push_back($urandom);
          do_program($sformatf("rnd%0d_prg", it), words);
        end
        1: do_step($sformatf("rnd%0d_step", it), ($urandom_range(0, 3) == 0), rand_dbg());
        2: do_run($sformatf("rnd%0d_run", it), $urandom_range(1, 30), ($urandom_range(0, 3) == 0));
        3: do_dump($sformatf("rnd%0d_dump", it));
        default: begin
          tx0 = tx_q.size();
          send_byte(8'($urandom_range(5, 255)), 0);
          check($sformatf("rnd%0d_unknown_state", it), 64'(state_out), 64'd0);
          repeat (2) @(negedge clk);
          check($sformatf("rnd%0d_unknown_no_tx", it), 64'(tx_q.size() - tx0), 64'd0);
        end
      endcase
    end

    check("tx_start_before_done", 64'(gap_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Parametrised successor to the fixed-function MIPS debug unit.
- Sits between the UART byte interface and TOP_MIPS. It decodes a byte command protocol to:
  - load instruction memory;
  - gate the MIPS clock in run or single-step mode;
  - stream a snapshot of NUM_DBG_WORDS debug words (PC, latches, registers) back over UART.
- Word width, instruction-address width and debug-word count are parameters.

Parameters:
- NBIT_DATA_LEN, 8: UART byte width.
- len_data, 32: instruction and debug word width; must be a multiple of NBIT_DATA_LEN.
- INST_ADDR_W, 8: instruction-memory address width.
- NUM_DBG_WORDS, 4: number of len_data words in dbg_bus sent per dump.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle strobe; rx_data_in is valid.
- rx_data_in  in  NBIT_DATA_LEN  received byte.
- tx_done_tick  in  1  one-cycle strobe; UART finished the byte.
- tx_start  out  1  one-cycle strobe; send data_out.
- data_out  out  NBIT_DATA_LEN  byte to transmit.
- halt  in  1  MIPS halt flag (level).
- dbg_bus  in  NUM_DBG_WORDS*len_data  flattened debug words; word 0 in the LSBs.
- addr_mem_inst  out  INST_ADDR_W  instruction-memory write address.
- ins_to_mem  out  len_data  instruction write data.
- wr_ram_inst  out  1  one-cycle write enable.
- ctrl_clk_mips  out  1  MIPS clock enable.
- reset_mips  out  1  active-high MIPS reset pulse.
- state_out  out  4  current FSM state encoding, for LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0 and the FSM is in IDLE.
  - Counters and the shadow register are cleared.
  - Any transfer in progress is abandoned, with no partial write.
- Command bytes (accepted only in IDLE; unknown bytes are ignored and the FSM stays in IDLE):
  - 0x01 PROGRAM
  - 0x02 RUN
  - 0x03 STEP
  - 0x04 DUMP
- Bytes arriving in any non-receive state (RUN, STEP, DUMP_*) are dropped.
- PROGRAM:
  - IDLE->PRG_LEN. reset_mips is high for exactly 1 cycle on this transition, and the word address is cleared to 0.
  - In PRG_LEN the next byte is N, the word count. If N=0, go to PRG_ACK.
  - PRG_DATA assembles len_data/NBIT_DATA_LEN bytes, least-significant byte first.
  - On the cycle after the last byte of a word: wr_ram_inst=1 for 1 cycle, with ins_to_mem=word and addr_mem_inst=current address. The address then increments, wrapping modulo 2^INST_ADDR_W.
  - After N words go to PRG_ACK.
  - PRG_ACK sends byte 0xA5, waits for tx_done_tick, then returns to IDLE.
- RUN:
  - ctrl_clk_mips is 1 from the cycle after the command until halt is sampled high.
  - It drops on the cycle after halt is sampled, then the FSM enters DUMP_LOAD.
  - If halt is already high at command time, ctrl_clk_mips never asserts.
- STEP:
  - ctrl_clk_mips is high for exactly 1 cycle, then the FSM enters DUMP_LOAD.
  - If halt is already high, no pulse is issued; the FSM goes directly to DUMP_LOAD.
- DUMP (via command 0x04, or after RUN/STEP):
  - DUMP_LOAD copies dbg_bus into a shadow register in a single cycle, so the dump is coherent.
  - DUMP_SEND issues a 1-cycle tx_start with the current byte on data_out.
  - DUMP_WAIT holds until tx_done_tick.
  - Byte order: word 0 first; within each word, LSB first. Total bytes = NUM_DBG_WORDS*len_data/NBIT_DATA_LEN.
  - After the final tx_done_tick, return to IDLE.
- data_out holds its value until the next tx_start.
- tx_start is never reasserted before tx_done_tick.
- rx_done_tick and tx_done_tick arriving in the same cycle: each is handled by its own state; there is no interaction.

Decomposition:
- Package debug_pkg holds:
  - command-code constants;
  - the ACK byte constant 0xA5;
  - the FSM state encoding (also driven onto state_out);
  - the BYTES_PER_WORD localparam function.
- One sub-module: byte_serializer. It loads a wide word, exposes the current byte, and takes a shift strobe. The dump path uses it; word assembly for PROGRAM stays inline.

Test Plan:
1. PROGRAM, N=2, bytes 78 56 34 12 EF BE AD DE -> reset_mips pulses once; two wr_ram_inst pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; then TX 0xA5.
2. STEP with halt=0, dbg_bus={0x4,0x3,0x2,0x1} -> ctrl_clk_mips high exactly 1 cycle; then 16 TX bytes: 01 00 00 00 02 00 00 00 03 00 00 00 04 00 00 00.
3. RUN, halt raised 50 cycles later -> ctrl_clk_mips high for 50 cycles and low the cycle after halt is sampled; dump follows.
4. DUMP with dbg_bus changing during transmission -> transmitted bytes equal the value latched in DUMP_LOAD.
5. Byte 0x7F in IDLE, then 0x04 -> 0x7F ignored; dump proceeds normally.
6. reset asserted mid-PRG_DATA (after 2 bytes) -> outputs 0 immediately and no wr_ram_inst. A subsequent PROGRAM with N=1 writes at addr 0.
